udp_send_mux: RTL and testbench

- Multi-channel successor of the single-source UDP framer.
- Arbitrates round-robin among NCH payload sources and prepends an 8-byte UDP header (source port, destination port, length, zero checksum).
- Pulls payload bytes from the granted channel's FIFO and streams header plus payload as one byte stream toward the IP layer.
- Enforces a maximum payload length and a minimum inter-datagram gap.

---
 rtl/udp_pkg.sv | 37 +++
 rtl/udp_send_mux_if.sv | 26 ++
 rtl/udp_send_mux_rr_arbiter.sv | 42 ++++
 rtl/udp_send_mux.sv | 132 +++++++++++++
 tb/tb_udp_send_mux.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/udp_pkg.sv
// Shared definitions for the multi-channel UDP framer: header constants,
// FSM encoding, the latched header payload and a header byte selector.
package udp_pkg;

  localparam int unsigned UDP_HDR_LEN       = 8;
  localparam logic [15:0] UDP_CHECKSUM_NONE = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAY,
    ST_GAP
  } state_t;

  typedef struct packed {
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] ulen;
  } udp_hdr_t;

  // Byte idx (0..7) of the on-wire UDP header, most significant byte first.
  function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input udp_hdr_t h);
    logic [7:0] b;
    case (idx)
      3'd0:    b = h.src[15:8];
      3'd1:    b = h.src[7:0];
      3'd2:    b = h.dst[15:8];
      3'd3:    b = h.dst[7:0];
      3'd4:    b = h.ulen[15:8];
      3'd5:    b = h.ulen[7:0];
      3'd6:    b = UDP_CHECKSUM_NONE[15:8];
      default: b = UDP_CHECKSUM_NONE[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/udp_send_mux_if.sv
// Channel-side request/payload bus plus the framed byte stream toward IP.
interface udp_send_mux_if #(
  parameter int unsigned NCH = 4
);
  logic [NCH-1:0]    req;
  logic [NCH*16-1:0] length_in;
  logic [NCH*16-1:0] destination_port;
  logic [NCH*8-1:0]  port_ID;
  logic [NCH*8-1:0]  data_in;
  logic [NCH-1:0]    grant;
  logic [NCH-1:0]    rd;
  logic [NCH-1:0]    reject;
  logic              active;
  logic [7:0]        data_out;
  logic [15:0]       length_out;

  modport master (
    output req, length_in, destination_port, port_ID, data_in,
    input  grant, rd, reject, active, data_out, length_out
  );

  modport slave (
    input  req, length_in, destination_port, port_ID, data_in,
    output grant, rd, reject, active, data_out, length_out
  );
endinterface

// File: rtl/udp_send_mux_rr_arbiter.sv
// Round-robin arbiter: scans req from the pointer upward with wrap, and moves
// the pointer one past the winner whenever the winner is consumed.
module rr_arbiter #(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [NCH-1:0] req,
  input  logic           advance,
  output logic [NCH-1:0] win_c,
  output logic [CW-1:0]  win_idx_c,
  output logic           any_c
);

  logic [CW-1:0] ptr;

  always_comb begin
    int j;
    j         = 0;
    win_idx_c = '0;
    any_c     = 1'b0;
    for (int k = 0; k < int'(NCH); k++) begin
      j = int'(ptr) + k;
      if (j >= int'(NCH)) j = j - int'(NCH);
      if (!any_c && req[j]) begin
        any_c     = 1'b1;
        win_idx_c = CW'(j);
      end
    end
    win_c = any_c ? (NCH'(1) << win_idx_c) : '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (win_idx_c == CW'(NCH - 1)) ? '0 : win_idx_c + 1'b1;
    end
  end

endmodule

// File: rtl/udp_send_mux.sv
// Multi-channel UDP framer: round-robin picks a source, emits the 8-byte
// header, streams the payload from that channel's FIFO, then holds a gap.
module udp_send_mux
  import udp_pkg::*;
#(
  parameter int unsigned NCH         = 4,
  parameter int unsigned MAX_PAYLOAD = 1444,
  parameter int unsigned IFG_CYCLES  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [15:0]       local_port,
  udp_send_mux_if.slave     bus
);

  localparam int unsigned CW       = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [3:0]  GAP_LOAD = (IFG_CYCLES > 0) ? 4'(IFG_CYCLES - 1) : 4'd0;

  state_t         state;
  udp_hdr_t       hdr;
  logic [CW-1:0]  cur;
  logic [2:0]     hidx;
  logic [15:0]    rd_cnt;
  logic [15:0]    pay_cnt;
  logic [3:0]     gap_cnt;

  logic [NCH-1:0] win_c;
  logic [CW-1:0]  win_idx_c;
  logic           any_c;
  logic           advance_c;
  logic [15:0]    sel_len_c;
  logic [15:0]    sel_dst_c;
  logic [7:0]     sel_pid_c;
  logic [15:0]    src_c;
  logic           illegal_c;
  logic [7:0]     cur_data_c;

  // Per-channel field selection for the current winner and the granted channel.
  always_comb begin
    sel_len_c  = bus.length_in[16*int'(win_idx_c) +: 16];
    sel_dst_c  = bus.destination_port[16*int'(win_idx_c) +: 16];
    sel_pid_c  = bus.port_ID[8*int'(win_idx_c) +: 8];
    src_c      = local_port + 16'(sel_pid_c);
    illegal_c  = sel_len_c > 16'(MAX_PAYLOAD);
    cur_data_c = bus.data_in[8*int'(cur) +: 8];
    advance_c  = (state == ST_IDLE) && any_c;
  end

  rr_arbiter #(
    .NCH (NCH),
    .CW  (CW)
  ) u_arb (
    .clock     (clock),
    .reset     (reset),
    .req       (bus.req),
    .advance   (advance_c),
    .win_c     (win_c),
    .win_idx_c (win_idx_c),
    .any_c     (any_c)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= ST_IDLE;
      hdr            <= '0;
      cur            <= '0;
      hidx           <= '0;
      rd_cnt         <= '0;
      pay_cnt        <= '0;
      gap_cnt        <= '0;
      bus.grant      <= '0;
      bus.rd         <= '0;
      bus.reject     <= '0;
      bus.active     <= 1'b0;
      bus.data_out   <= '0;
      bus.length_out <= '0;
    end else begin
      bus.rd     <= '0;
      bus.reject <= '0;
      case (state)
        ST_IDLE: begin
          if (any_c) begin
            if (illegal_c) begin
              bus.reject <= win_c;
            end else begin
              hdr            <= '{src: src_c, dst: sel_dst_c, ulen: sel_len_c + 16'(UDP_HDR_LEN)};
              cur            <= win_idx_c;
              rd_cnt         <= sel_len_c;
              pay_cnt        <= sel_len_c;
              hidx           <= '0;
              bus.grant      <= win_c;
              bus.active     <= 1'b1;
              bus.data_out   <= src_c[15:8];
              bus.length_out <= sel_len_c + 16'(UDP_HDR_LEN);
              state          <= ST_HDR;
            end
          end
        end

        ST_HDR, ST_PAY: begin
          // Reads start two cycles ahead of the first payload byte slot.
          if (hidx >= 3'd5 && rd_cnt != '0) begin
            bus.rd <= bus.grant;
            rd_cnt <= rd_cnt - 16'd1;
          end
          if (state == ST_HDR && hidx != 3'd7) begin
            hidx         <= hidx + 3'd1;
            bus.data_out <= hdr_byte(hidx + 3'd1, hdr);
          end else if (pay_cnt == '0) begin
            bus.active   <= 1'b0;
            bus.grant    <= '0;
            bus.data_out <= '0;
            gap_cnt      <= GAP_LOAD;
            state        <= (IFG_CYCLES == 0) ? ST_IDLE : ST_GAP;
          end else begin
            bus.data_out <= cur_data_c;
            pay_cnt      <= pay_cnt - 16'd1;
            state        <= ST_PAY;
          end
        end

        ST_GAP: begin
          if (gap_cnt == '0) state <= ST_IDLE;
          else               gap_cnt <= gap_cnt - 4'd1;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_send_mux.sv
// Self-checking bench for udp_send_mux: directed scenarios plus random
// multi-channel rounds checked against a datagram-level reference model.
module tb_udp_send_mux;

  localparam int NCH  = 4;
  localparam int MAXP = 1444;
  localparam int IFG  = 2;

  logic        clock;
  logic        reset;
  logic [15:0] local_port;

  udp_send_mux_if #(.NCH(NCH)) bus ();

  udp_send_mux #(
    .NCH         (NCH),
    .MAX_PAYLOAD (MAXP),
    .IFG_CYCLES  (IFG)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .local_port (local_port),
    .bus        (bus)
  );

  int checks = 0;
  int errors = 0;
  int mptr   = 0;

  int          cfg_len [NCH];
  logic [15:0] cfg_dst [NCH];
  logic [7:0]  cfg_pid [NCH];
  logic [7:0]  fifo_q  [NCH][$];
  logic [7:0]  exp_pay [NCH][$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $fatal(1, "FAIL watchdog: simulation did not finish");
  end

  // Payload FIFOs with one-cycle read latency; junk when not read.
  always @(posedge clock) begin
    for (int c = 0; c < NCH; c++) begin
      if (bus.rd[c] && fifo_q[c].size() > 0) bus.data_in[c*8 +: 8] <= fifo_q[c].pop_front();
      else                                    bus.data_in[c*8 +: 8] <= 8'($urandom);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NCH-1:0] m);
    for (int k = 0; k < NCH; k++) begin
      int j;
      j = (mptr + k) % NCH;
      if (m[j]) return j;
    end
    return -1;
  endfunction

  task automatic load_ch(input int c, input int len, input logic [15:0] dst,
                         input logic [7:0] pid, input bit rnd);
    logic [7:0] b;
    cfg_len[c] = len;
    cfg_dst[c] = dst;
    cfg_pid[c] = pid;
    bus.length_in[c*16 +: 16]        = 16'(len);
    bus.destination_port[c*16 +: 16] = dst;
    bus.port_ID[c*8 +: 8]            = pid;
    if (rnd) begin
      repeat (len) begin
        b = 8'($urandom);
        fifo_q[c].push_back(b);
        exp_pay[c].push_back(b);
      end
    end
  endtask

  task automatic push_byte(input int c, input logic [7:0] b);
    fifo_q[c].push_back(b);
    exp_pay[c].push_back(b);
  endtask

  // Wait for the next datagram, then check every byte, rd and grant cycle.
  task automatic expect_dgram(input int c, input int exp_wait,
                              input logic [NCH-1:0] drop, input bit poke_dst);
    int          waited;
    int          len;
    logic [15:0] src, dst, ulen;
    logic [7:0]  hb [8];
    logic [7:0]  eb;
    len  = cfg_len[c];
    src  = 16'((int'(local_port) + int'(cfg_pid[c])) % 65536);
    dst  = cfg_dst[c];
    ulen = 16'(len + 8);
    hb   = '{src[15:8], src[7:0], dst[15:8], dst[7:0], ulen[15:8], ulen[7:0], 8'h00, 8'h00};
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
      if (!bus.active) chk("idle_quiet", {bus.grant, bus.rd, bus.data_out}, 32'd0);
    end while (!bus.active && waited < 200);
    chk("dgram_start", 32'(bus.active), 32'd1);
    if (!bus.active) return;
    if (exp_wait >= 0) chk("gap_cycles", 32'(waited), 32'(exp_wait));
    bus.req = bus.req & ~drop;
    for (int i = 1; i <= 8 + len; i++) begin
      if (i > 1) @(negedge clock);
      if (poke_dst && i == 3) bus.destination_port[c*16 +: 16] = 16'($urandom);
      eb = (i <= 8) ? hb[i-1] : exp_pay[c].pop_front();
      chk("active",     32'(bus.active),     32'd1);
      chk("grant",      32'(bus.grant),      32'(1 << c));
      chk("data_out",   32'(bus.data_out),   32'(eb));
      chk("length_out", 32'(bus.length_out), 32'(ulen));
      chk("rd",         32'(bus.rd),         (i >= 7 && i <= 6 + len) ? 32'(1 << c) : 32'd0);
      chk("reject",     32'(bus.reject),     32'd0);
    end
    @(negedge clock);
    chk("dgram_end", {bus.active, bus.grant, bus.data_out}, 32'd0);
  endtask

  initial begin
    int          waited;
    int          c;
    logic [NCH-1:0] m, rem;
    bit          first;

    reset = 1'b0;
    local_port = '0;
    bus.req = '0;
    bus.length_in = '0;
    bus.destination_port = '0;
    bus.port_ID = '0;
    repeat (3) @(negedge clock);
    chk("rst_active", 32'(bus.active),     32'd0);
    chk("rst_grant",  32'(bus.grant),      32'd0);
    chk("rst_rd",     32'(bus.rd),         32'd0);
    chk("rst_reject", 32'(bus.reject),     32'd0);
    chk("rst_data",   32'(bus.data_out),   32'd0);
    chk("rst_len",    32'(bus.length_out), 32'd0);
    reset = 1'b1;
    mptr  = 0;

    // Single channel 2, fixed payload.
    local_port = 16'd1024;
    load_ch(2, 4, 16'h1F40, 8'd3, 1'b0);
    push_byte(2, 8'hAA); push_byte(2, 8'hBB); push_byte(2, 8'hCC); push_byte(2, 8'hDD);
    bus.req = 4'b0100;
    c = pick(bus.req); mptr = (c + 1) % NCH;
    expect_dgram(c, 1, 4'b0100, 1'b0);

    // Zero-length datagram on channel 0.
    load_ch(0, 0, 16'($urandom), 8'($urandom), 1'b1);
    bus.req = 4'b0001;
    c = pick(bus.req); mptr = (c + 1) % NCH;
    expect_dgram(c, IFG + 1, 4'b0001, 1'b0);

    // Oversized request on ch1 is rejected; pending ch2 is served next.
    load_ch(1, MAXP + 1, 16'($urandom), 8'($urandom), 1'b0);
    load_ch(2, 3, 16'($urandom), 8'($urandom), 1'b1);
    bus.req = 4'b0110;
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
      chk("rej_no_rd", 32'(bus.rd), 32'd0);
    end while (bus.reject == '0 && !bus.active && waited < 50);
    chk("rej_gap",    32'(waited),      32'(IFG + 1));
    chk("rej_pulse",  32'(bus.reject),  32'b0010);
    chk("rej_active", 32'(bus.active),  32'd0);
    bus.req[1] = 1'b0;
    c = pick(4'b0010); mptr = (c + 1) % NCH;
    c = pick(4'b0100); mptr = (c + 1) % NCH;
    expect_dgram(c, 1, 4'b0100, 1'b0);

    // Reset in the middle of a header.
    load_ch(3, 5, 16'($urandom), 8'($urandom), 1'b1);
    bus.req = 4'b1000;
    waited = 0;
    do begin @(negedge clock); waited++; end while (!bus.active && waited < 50);
    chk("mid_start", 32'(bus.grant), 32'b1000);
    bus.req = '0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("mid_active", 32'(bus.active),   32'd0);
    chk("mid_grant",  32'(bus.grant),    32'd0);
    chk("mid_rd",     32'(bus.rd),       32'd0);
    chk("mid_data",   32'(bus.data_out), 32'd0);
    repeat (3) begin
      @(negedge clock);
      chk("mid_rd_hold", 32'(bus.rd), 32'd0);
    end
    fifo_q[3].delete();
    exp_pay[3].delete();
    reset = 1'b1;
    mptr  = 0;

    // All channels requesting continuously.
    for (int k = 0; k < NCH; k++) load_ch(k, 2, 16'($urandom), 8'($urandom), 1'b1);
    load_ch(0, 2, cfg_dst[0], cfg_pid[0], 1'b1);
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      c = pick(4'b1111); mptr = (c + 1) % NCH;
      expect_dgram(c, (k == 0) ? 1 : IFG + 1, (k == 4) ? 4'b1111 : 4'b0000, 1'b0);
    end

    // Source-port wrap and destination change after grant.
    local_port = 16'hFFF0;
    load_ch(1, $urandom_range(1, 6), 16'($urandom), 8'hFF, 1'b1);
    bus.req = 4'b0010;
    c = pick(bus.req); mptr = (c + 1) % NCH;
    expect_dgram(c, -1, 4'b0010, 1'b1);

    // Random rounds over random channel sets.
    repeat (6) begin
      local_port = 16'($urandom);
      m = 4'($urandom_range(1, 15));
      for (int k = 0; k < NCH; k++)
        if (m[k]) load_ch(k, $urandom_range(0, 12), 16'($urandom), 8'($urandom), 1'b1);
      bus.req = m;
      rem = m;
      first = 1'b1;
      while (rem != '0) begin
        c = pick(rem); mptr = (c + 1) % NCH;
        expect_dgram(c, first ? -1 : IFG + 1, 4'(1 << c), 1'b0);
        rem[c] = 1'b0;
        first = 1'b0;
      end
    end

    repeat (5) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
